divmmc_ram_arbiter: RTL and testbench
=====================================

# divmmc_ram_arbiter

Arbitrates the single-port external SRAM that backs DivMMC ROM and RAM. Two requesters share it: Z80 accesses that fall inside the mapped 0000–3FFF window, and the HPS download (ioctl) port that loads the esxDOS image and pre-fills RAM pages. The block sits between the DivMMC mapper outputs (`mapped`, `ramcs`, `page`) and the SRAM pins. It also enforces write protection and the fixed physical address map.

## Interface
Parameters:
- none

Ports:
- `clock` in 1: system clock; at least 4× the CPU clock.
- `reset` in 1: asynchronous, active-low.
- `mapped` in 1: DivMMC memory paged into 0000–3FFF (from mapper).
- `ramcs` in 1: access targets DivMMC RAM rather than ROM (from mapper).
- `page` in 4: RAM page for the access (from mapper).
- `mreq` in 1: Z80 MREQ, active-low.
- `rd` in 1: Z80 RD, active-low.
- `wr` in 1: Z80 WR, active-low.
- `a` in 14: Z80 address bits 13:0.
- `d` in 8: Z80 data out.
- `q` out 8: read data to CPU data bus mux.
- `dl_req` in 1: download write request, level.
- `dl_addr` in 18: download physical address.
- `dl_data` in 8: download byte.
- `dl_ack` out 1: one-clock pulse when the download byte has been written.
- `mem_addr` out 18: SRAM address.
- `mem_d` out 8: SRAM write data.
- `mem_q` in 8: SRAM read data.
- `mem_we` out 1: SRAM write strobe, active-high.
- `mem_oe` out 1: SRAM output enable, active-high.

## Operation
- Physical map:
  - RAM page n occupies n×0x2000 .. n×0x2000+0x1FFF, i.e. 0x00000–0x1FFFF.
  - ROM occupies 0x20000–0x21FFF.
  - 0x22000–0x3FFFF is unused. Download writes there complete normally but are don't-care.
- CPU address:
  - `ramcs`=1 → {1'b0, `page`, `a[12:0]`}.
  - `ramcs`=0 → {5'b10000, `a[12:0]`}.
- CPU request: `mapped` && !`mreq` && (!`rd` || !`wr`). It is sampled every clock, not gated by CPU ce.
- Write protect: a CPU write with `a[13]`=0 (ROM, or mapram page 3) never asserts `mem_we`. It is still arbitrated and consumes its slot.
- FSM states:
  - IDLE:
    - CPU request with !`rd` → CRD.
    - CPU request with !`wr` → CWR.
    - Otherwise `dl_req` → DW1.
  - CRD: `mem_oe`=1, address driven → CRD2.
  - CRD2: `q` <= `mem_q` → CDONE.
  - CWR: `mem_d` <= `d`; `mem_we`=1 unless protected → CDONE.
  - CDONE: outputs idle. Stay while `mreq` is low; return to IDLE when `mreq` is high. One CPU cycle gets exactly one memory access.
  - DW1: `mem_addr` <= `dl_addr`, `mem_d` <= `dl_data`, `mem_we`=0 (setup) → DW2.
  - DW2: `mem_we`=1, `dl_ack`=1 for this clock → IDLE.
- Priority:
  - CPU beats download in IDLE.
  - An in-flight download (DW1/DW2) is never aborted; a CPU request waits at most 2 clocks.
  - A download may start only from IDLE. It is never started while in CDONE.
- Download handshake:
  - Loader holds `dl_req`, `dl_addr` and `dl_data` stable until it sees `dl_ack`.
  - If `dl_req` is still high in IDLE after the ack, a new write starts, so back-to-back bytes run at 1 per 3 clocks minimum.
- `q` holds the last CPU read value until the next CRD2.
- Reset mid-operation: state → IDLE immediately. `mem_we`, `mem_oe` and `dl_ack` deassert asynchronously. The pending download is not acked; the loader retries.

## Timing
- Reset values:
  - `q`=8'hFF, `mem_addr`=0, `mem_d`=0.
  - `mem_we`=0, `mem_oe`=0, `dl_ack`=0.
  - FSM=IDLE.
- All outputs are registered.
- CPU read latency: `q` is valid ≤ 4 clocks after `mreq`/`rd` fall, i.e. 2 worst-case download drain + CRD + CRD2.
- CPU write latency: `mem_we` pulse ≤ 3 clocks after `mreq`/`wr` fall; it lasts exactly 1 clock.
- `dl_ack` is a 1-clock pulse, coincident with the `mem_we` clock of DW2.
- Simultaneous CPU request and `dl_req` in IDLE → the CPU is served first. The download starts on the first IDLE after `mreq` rises.
- `mapped` falling during CDONE has no effect; exit from CDONE is on `mreq` only.

## Test plan
- Reset: hold `reset`=0 → `q`=FF, `mem_we`=`mem_oe`=`dl_ack`=0. Release with no requests → outputs unchanged, FSM idle.
- CPU RAM read: `mapped`=1, `ramcs`=1, `page`=5, `a`=0x2123, `mem_q`=0x5A → `mem_addr`=0x0A123 with `mem_oe`=1 for 1 clock; `q`=0x5A within 4 clocks and held after `mreq` rises.
- Write protect:
  - CPU write with `ramcs`=0, `a`=0x0100 → no `mem_we`.
  - CPU write with `ramcs`=1, `page`=3, `a`=0x0100 → no `mem_we`.
  - Same with `a`=0x2100 → `mem_we` pulse at `mem_addr`=0x06100, `mem_d`=`d`.
- Download burst: `dl_req` held high across 4 bytes to 0x20000..0x20003 → 4 `dl_ack` pulses 3 clocks apart; `mem_we` asserted only in DW2 clocks with matching address/data.
- Collision: `dl_req` and CPU read asserted on the same clock → CPU read completes first; `dl_ack` arrives only after `mreq` rises. CPU read arriving during DW1 → `q` still valid ≤ 4 clocks.
- Reset mid-download: assert `reset` during DW1 → `mem_we`=0 immediately, no `dl_ack`. After release with `dl_req` still high → write re-executes and acks once.

Source files
------------

// File: rtl/divmmc_ram_arbiter.sv
// SRAM arbiter for DivMMC ROM/RAM: serves mapped Z80 accesses and HPS download writes
// on one single-port SRAM, with ROM/mapram write protection and the fixed physical map.
module divmmc_ram_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        mapped,
  input  logic        ramcs,
  input  logic [3:0]  page,
  input  logic        mreq,
  input  logic        rd,
  input  logic        wr,
  input  logic [13:0] a,
  input  logic [7:0]  d,
  output logic [7:0]  q,
  input  logic        dl_req,
  input  logic [17:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_ack,
  output logic [17:0] mem_addr,
  output logic [7:0]  mem_d,
  input  logic [7:0]  mem_q,
  output logic        mem_we,
  output logic        mem_oe
);

  // state | meaning
  // IDLE  | no access in flight; CPU request wins over download
  // CRD   | CPU read, SRAM output enabled, data sampled at end of clock
  // CRD2  | CPU read data presented on q
  // CWR   | CPU write strobe (suppressed for a[13]=0)
  // CDONE | CPU access served, wait for mreq to rise
  // DW1   | download address/data setup, strobe low
  // DW2   | download write strobe and ack
  typedef enum logic [2:0] {
    S_IDLE, S_CRD, S_CRD2, S_CWR, S_CDONE, S_DW1, S_DW2
  } state_t;

  state_t state, state_nxt;

  logic        cpu_req;
  logic [17:0] cpu_addr;

  logic [7:0]  q_nxt;
  logic [17:0] mem_addr_nxt;
  logic [7:0]  mem_d_nxt;
  logic        mem_we_nxt;
  logic        mem_oe_nxt;
  logic        dl_ack_nxt;

  assign cpu_req  = mapped && !mreq && (!rd || !wr);
  assign cpu_addr = ramcs ? {1'b0, page, a[12:0]} : {5'b10000, a[12:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cpu_req && !rd)      state_nxt = S_CRD;
        else if (cpu_req && !wr) state_nxt = S_CWR;
        else if (dl_req)         state_nxt = S_DW1;
      end
      S_CRD:   state_nxt = S_CRD2;
      S_CRD2:  state_nxt = S_CDONE;
      S_CWR:   state_nxt = S_CDONE;
      // exit only on mreq so a single CPU cycle never gets a second access
      S_CDONE: if (mreq) state_nxt = S_IDLE;
      S_DW1:   state_nxt = S_DW2;
      S_DW2:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    q_nxt        = q;
    mem_addr_nxt = mem_addr;
    mem_d_nxt    = mem_d;
    mem_we_nxt   = 1'b0;
    mem_oe_nxt   = 1'b0;
    dl_ack_nxt   = 1'b0;
    case (state_nxt)
      S_CRD: begin
        mem_oe_nxt   = 1'b1;
        mem_addr_nxt = cpu_addr;
      end
      S_CRD2: q_nxt = mem_q;
      S_CWR: begin
        mem_addr_nxt = cpu_addr;
        mem_d_nxt    = d;
        mem_we_nxt   = a[13];
      end
      S_DW1: begin
        mem_addr_nxt = dl_addr;
        mem_d_nxt    = dl_data;
      end
      S_DW2: begin
        mem_we_nxt = 1'b1;
        dl_ack_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q        <= 8'hFF;
      mem_addr <= 18'h0;
      mem_d    <= 8'h0;
      mem_we   <= 1'b0;
      mem_oe   <= 1'b0;
      dl_ack   <= 1'b0;
    end else begin
      q        <= q_nxt;
      mem_addr <= mem_addr_nxt;
      mem_d    <= mem_d_nxt;
      mem_we   <= mem_we_nxt;
      mem_oe   <= mem_oe_nxt;
      dl_ack   <= dl_ack_nxt;
    end
  end

endmodule

// File: tb/tb_divmmc_ram_arbiter.sv
// Bench for divmmc_ram_arbiter: CPU reads/writes and downloads against an address-map
// and write-list reference model.
module tb_divmmc_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        mapped, ramcs, mreq, rd, wr;
  logic [3:0]  page;
  logic [13:0] a;
  logic [7:0]  d, q;
  logic        dl_req, dl_ack;
  logic [17:0] dl_addr, mem_addr;
  logic [7:0]  dl_data, mem_d, mem_q;
  logic        mem_we, mem_oe;

  int pass_cnt = 0;
  int total_cnt = 0;

  int oe_count = 0;
  logic [17:0] oe_addr = '0;
  int ack_count = 0;
  int ack_no_we = 0;
  logic [25:0] wr_log[$];
  logic [7:0] last_mq = 8'hFF;

  divmmc_ram_arbiter dut (
    .clock(clock), .reset(reset), .mapped(mapped), .ramcs(ramcs), .page(page),
    .mreq(mreq), .rd(rd), .wr(wr), .a(a), .d(d), .q(q),
    .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack),
    .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q), .mem_we(mem_we), .mem_oe(mem_oe)
  );

  always #5 clock = ~clock;

  // Observe the SRAM pins mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      if (mem_oe) begin
        oe_count++;
        oe_addr = mem_addr;
      end
      if (mem_we) wr_log.push_back({mem_addr, mem_d});
      if (dl_ack) begin
        ack_count++;
        if (!mem_we) ack_no_we++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [17:0] model_addr(input logic cs, input logic [3:0] pg,
                                             input logic [13:0] aa);
    int off;
    off = int'(aa) % 8192;
    if (cs) return 18'(int'(pg) * 8192 + off);
    return 18'(131072 + off);
  endfunction

  function automatic logic [7:0] next_mq();
    return last_mq ^ 8'($urandom_range(1, 255));
  endfunction

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    mapped = 0; ramcs = 0; page = 0; mreq = 1; rd = 1; wr = 1; a = 0; d = 0;
    dl_req = 0; dl_addr = 0; dl_data = 0;
  endtask

  task automatic cpu_read(input logic r_cs, input logic [3:0] r_pg, input logic [13:0] r_a,
                          input logic [7:0] mq, input string name);
    logic [17:0] ea;
    ea = model_addr(r_cs, r_pg, r_a);
    oe_count = 0;
    mapped = 1; ramcs = r_cs; page = r_pg; a = r_a; mem_q = mq; mreq = 0; rd = 0;
    repeat (4) tick();
    total_cnt++;
    if (q !== mq) $display("FAIL %s_q: got %h expected %h", name, q, mq);
    else pass_cnt++;
    mreq = 1; rd = 1; mem_q = ~mq; mapped = 1'($urandom_range(0, 1));
    repeat (2) tick();
    total_cnt++;
    if (oe_count !== 1 || oe_addr !== ea)
      $display("FAIL %s_oe: got %0d clocks at %h expected 1 clock at %h", name, oe_count, oe_addr, ea);
    else pass_cnt++;
    total_cnt++;
    if (q !== mq) $display("FAIL %s_hold: got %h expected %h", name, q, mq);
    else pass_cnt++;
    last_mq = mq;
  endtask

  task automatic cpu_write(input logic w_map, input logic w_cs, input logic [3:0] w_pg,
                           input logic [13:0] w_a, input logic [7:0] w_d, input string name);
    logic [25:0] exp_w;
    int exp_n;
    exp_n = (w_map && w_a >= 14'h2000) ? 1 : 0;
    exp_w = {model_addr(w_cs, w_pg, w_a), w_d};
    wr_log.delete();
    mapped = w_map; ramcs = w_cs; page = w_pg; a = w_a; d = w_d; mreq = 0; wr = 0;
    repeat (3) tick();
    total_cnt++;
    if (wr_log.size() != exp_n || (exp_n == 1 && wr_log[0] !== exp_w))
      $display("FAIL %s_we: got %0d strobes expected %0d at %h", name, wr_log.size(), exp_n, exp_w);
    else pass_cnt++;
    mreq = 1; wr = 1; d = ~w_d;
    repeat (2) tick();
    total_cnt++;
    if (wr_log.size() != exp_n)
      $display("FAIL %s_len: got %0d strobe clocks expected %0d", name, wr_log.size(), exp_n);
    else pass_cnt++;
  endtask

  task automatic dl_one(input logic [17:0] ad, input logic [7:0] dt, input string name);
    bit got;
    got = 0;
    wr_log.delete();
    ack_count = 0;
    dl_req = 1; dl_addr = ad; dl_data = dt;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (dl_ack) begin
        got = 1;
        dl_req = 0;
      end
    end
    repeat (2) tick();
    total_cnt++;
    if (!got || ack_count != 1 || wr_log.size() != 1 || wr_log[0] !== {ad, dt})
      $display("FAIL %s: got %0d acks %0d writes expected 1 ack 1 write of %h", name, ack_count,
               wr_log.size(), {ad, dt});
    else pass_cnt++;
    dl_req = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    mem_q = 8'h00;
    repeat (3) tick();
    total_cnt++;
    if ({q, mem_we, mem_oe, dl_ack} !== {8'hFF, 3'b000})
      $display("FAIL reset_outputs: got q=%h we=%b oe=%b ack=%b expected FF 0 0 0", q, mem_we, mem_oe, dl_ack);
    else pass_cnt++;
    total_cnt++;
    if ({mem_addr, mem_d} !== 26'h0)
      $display("FAIL reset_bus: got addr=%h d=%h expected 0 0", mem_addr, mem_d);
    else pass_cnt++;
    reset = 1;
    repeat (4) tick();
    total_cnt++;
    if ({q, mem_we, mem_oe, dl_ack, mem_addr, mem_d} !== {8'hFF, 3'b000, 18'h0, 8'h0})
      $display("FAIL reset_release: got q=%h we=%b oe=%b ack=%b addr=%h expected idle", q, mem_we, mem_oe, dl_ack, mem_addr);
    else pass_cnt++;
  endtask

  task automatic test_cpu_read();
    cpu_read(1'b1, 4'd5, 14'h2123, 8'h5A, "read_page5");
    for (int i = 0; i < 6; i++)
      cpu_read(1'($urandom_range(0, 1)), 4'($urandom), 14'($urandom), next_mq(), "read_rand");
  endtask

  task automatic test_write_protect();
    cpu_write(1'b1, 1'b0, 4'd0, 14'h0100, 8'hA5, "wp_rom");
    cpu_write(1'b1, 1'b1, 4'd3, 14'h0100, 8'hC3, "wp_mapram");
    cpu_write(1'b1, 1'b1, 4'd3, 14'h2100, 8'h3C, "wr_page3");
    cpu_write(1'b0, 1'b1, 4'd3, 14'h2100, 8'h77, "wr_unmapped");
    for (int i = 0; i < 6; i++)
      cpu_write(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), 14'($urandom), 8'($urandom), "wr_rand");
  endtask

  task automatic test_download_burst();
    logic [7:0] data[4];
    int idx, cyc, last, bad_gap;
    for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
    wr_log.delete();
    ack_count = 0; ack_no_we = 0;
    idx = 0; cyc = 0; last = 0; bad_gap = 0;
    dl_req = 1; dl_addr = 18'h20000; dl_data = data[0];
    while (idx < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (dl_ack) begin
        if (idx > 0 && cyc - last != 3) bad_gap++;
        last = cyc;
        idx++;
        if (idx < 4) begin
          dl_addr = 18'h20000 + 18'(idx);
          dl_data = data[idx];
        end else dl_req = 0;
      end
    end
    dl_req = 0;
    repeat (3) tick();
    total_cnt++;
    if (idx != 4 || ack_count != 4)
      $display("FAIL burst_acks: got %0d acks expected 4", ack_count);
    else pass_cnt++;
    total_cnt++;
    if (bad_gap != 0) $display("FAIL burst_spacing: got %0d gaps not 3 clocks expected 0", bad_gap);
    else pass_cnt++;
    total_cnt++;
    if (ack_no_we != 0) $display("FAIL burst_ack_we: got %0d acks without strobe expected 0", ack_no_we);
    else pass_cnt++;
    total_cnt++;
    if (wr_log.size() != 4) $display("FAIL burst_writes: got %0d strobes expected 4", wr_log.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
      total_cnt++;
      if (wr_log[i] !== {18'h20000 + 18'(i), data[i]})
        $display("FAIL burst_byte%0d: got %h expected %h", i, wr_log[i], {18'h20000 + 18'(i), data[i]});
      else pass_cnt++;
    end
  endtask

  task automatic test_collision();
    logic [17:0] ad;
    logic [7:0] dt, mq;
    int wait_c;
    bit got;
    ad = 18'($urandom); dt = 8'($urandom); mq = next_mq();
    wr_log.delete(); ack_count = 0; oe_count = 0;
    dl_req = 1; dl_addr = ad; dl_data = dt;
    mapped = 1; ramcs = 1; page = 4'd9; a = 14'h3456; mem_q = mq; mreq = 0; rd = 0;
    repeat (4) tick();
    total_cnt++;
    if (q !== mq) $display("FAIL coll_q: got %h expected %h", q, mq);
    else pass_cnt++;
    repeat (2) tick();
    total_cnt++;
    if (ack_count != 0 || wr_log.size() != 0)
      $display("FAIL coll_no_early_dl: got %0d acks while mreq low expected 0", ack_count);
    else pass_cnt++;
    last_mq = mq;
    mreq = 1; rd = 1; mapped = 0;
    got = 0; wait_c = 0;
    while (!got && wait_c < 10) begin
      tick();
      wait_c++;
      if (dl_ack) begin
        got = 1;
        dl_req = 0;
      end
    end
    dl_req = 0;
    repeat (2) tick();
    total_cnt++;
    if (!got || wait_c != 3)
      $display("FAIL coll_ack_time: got ack after %0d clocks expected 3", wait_c);
    else pass_cnt++;
    total_cnt++;
    if (wr_log.size() != 1 || wr_log[0] !== {ad, dt})
      $display("FAIL coll_dl_write: got %0d writes expected 1 of %h", wr_log.size(), {ad, dt});
    else pass_cnt++;

    // CPU read arriving while a download is in its setup clock
    mq = next_mq(); ad = 18'($urandom); dt = 8'($urandom);
    dl_req = 1; dl_addr = ad; dl_data = dt;
    tick();
    oe_count = 0;
    mapped = 1; ramcs = 0; page = 4'd2; a = 14'h1ABC; mem_q = mq; mreq = 0; rd = 0;
    tick();
    total_cnt++;
    if (dl_ack !== 1'b1) $display("FAIL dw1_drain_ack: got %b expected 1", dl_ack);
    else pass_cnt++;
    dl_req = 0;
    repeat (3) tick();
    total_cnt++;
    if (q !== mq) $display("FAIL dw1_read_q: got %h expected %h", q, mq);
    else pass_cnt++;
    total_cnt++;
    if (oe_count != 1 || oe_addr !== model_addr(1'b0, 4'd2, 14'h1ABC))
      $display("FAIL dw1_read_oe: got %0d clocks at %h expected 1 at %h", oe_count, oe_addr,
               model_addr(1'b0, 4'd2, 14'h1ABC));
    else pass_cnt++;
    last_mq = mq;
    mreq = 1; rd = 1; mapped = 0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_download();
    logic [17:0] ad;
    logic [7:0] dt;
    bit got;
    ad = 18'($urandom); dt = 8'($urandom);
    dl_req = 1; dl_addr = ad; dl_data = dt;
    tick();
    #1 reset = 0;
    #1;
    total_cnt++;
    if ({mem_we, dl_ack, mem_oe} !== 3'b000)
      $display("FAIL rst_dw1: got we=%b ack=%b oe=%b expected 0 0 0", mem_we, dl_ack, mem_oe);
    else pass_cnt++;
    repeat (2) tick();
    wr_log.delete(); ack_count = 0;
    reset = 1;
    got = 0;
    for (int c = 0; c < 12 && !got; c++) begin
      tick();
      if (dl_ack) begin
        got = 1;
        dl_req = 0;
      end
    end
    dl_req = 0;
    repeat (4) tick();
    total_cnt++;
    if (ack_count != 1 || wr_log.size() != 1 || wr_log[0] !== {ad, dt})
      $display("FAIL rst_retry: got %0d acks %0d writes expected 1 ack 1 write of %h", ack_count,
               wr_log.size(), {ad, dt});
    else pass_cnt++;

    // reset landing on the strobe clock must drop it asynchronously
    dl_req = 1; dl_addr = 18'($urandom); dl_data = 8'($urandom);
    tick();
    tick();
    total_cnt++;
    if ({mem_we, dl_ack} !== 2'b11) $display("FAIL rst_pre_dw2: got we=%b ack=%b expected 1 1", mem_we, dl_ack);
    else pass_cnt++;
    #1 reset = 0;
    #1;
    total_cnt++;
    if ({mem_we, dl_ack} !== 2'b00) $display("FAIL rst_dw2_async: got we=%b ack=%b expected 0 0", mem_we, dl_ack);
    else pass_cnt++;
    dl_req = 0;
    tick();
    reset = 1;
    last_mq = 8'hFF;
    repeat (2) tick();
    total_cnt++;
    if (q !== 8'hFF) $display("FAIL rst_q: got %h expected FF", q);
    else pass_cnt++;
  endtask

  task automatic test_random_mix();
    for (int i = 0; i < 15; i++) begin
      case ($urandom_range(0, 2))
        0: cpu_read(1'($urandom_range(0, 1)), 4'($urandom), 14'($urandom), next_mq(), "mix_read");
        1: cpu_write(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), 14'($urandom), 8'($urandom), "mix_write");
        default: dl_one(18'($urandom), 8'($urandom), "mix_dl");
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_write_protect();
    test_download_burst();
    test_collision();
    test_reset_mid_download();
    test_random_mix();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
